cache_fill_ctrl: RTL

Parametrised two-port cache fill controller. It sits between the instruction and data caches and the shared multi-cycle memory. It latches one pending miss per port and arbitrates between them, with D over I. It issues one memory word address per cycle for the whole block, then steers returning words into the owning cache's data array, writing the tag on the final word.

---
 rtl/cache_fill_pkg.sv | 12 +
 rtl/cache_miss_latch.sv | 35 +++
 rtl/cache_fill_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cache_fill_pkg.sv
// Shared types and constants for the two-port cache fill controller.
package cache_fill_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/cache_miss_latch.sv
// One-deep pending-miss holder for a single cache port; the captured address
// stays valid until the arbiter grants the port and pulses clear_i.
module cache_miss_latch #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              busy_i,
  input  logic              clear_i,
  output logic              pending_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              pending_q;
  logic [ADDR_W-1:0] addr_q;

  // A busy port drops new misses, so set and clear never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
    end else if (clear_i) begin
      pending_q <= 1'b0;
    end else if (miss_i && !busy_i) begin
      pending_q <= 1'b1;
      addr_q    <= addr_i;
    end
  end

  assign pending_o = pending_q;
  assign addr_o    = addr_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Two-port (I/D) cache block fill controller with D-over-I arbitration.
// Optional CACHE_FILL_CRITICAL_WORD_FIRST_EN: fetch the missed word first, wrapping.
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WORD_BYTES  = 2,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           imiss_detected,
  input  logic [ADDR_W-1:0]              imiss_address,
  input  logic                           dmiss_detected,
  input  logic [ADDR_W-1:0]              dmiss_address,
  output logic                           ifsm_busy,
  output logic                           dfsm_busy,
  output logic                           fill_owner,
  output logic                           memory_req,
  output logic [ADDR_W-1:0]              memory_address,
  input  logic                           memory_data_valid,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] data_word_sel,
  output logic                           write_tag_array
);

  localparam int IW = $clog2(BLOCK_WORDS);
  localparam int CW = IW + 1;
  localparam int OW = $clog2(WORD_BYTES);
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(BLOCK_WORDS * WORD_BYTES - 1);
  localparam logic [CW-1:0]     BW_C     = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0]     LAST_C   = CW'(BLOCK_WORDS - 1);

  fill_state_t       state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IW-1:0]     start_q, start_d;
  logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]     recv_cnt_q, recv_cnt_d;

  logic              ipend, dpend, grant_i, grant_d;
  logic [ADDR_W-1:0] iaddr, daddr, grant_addr;
  logic [IW-1:0]     issue_idx, recv_idx;

  cache_miss_latch #(.ADDR_W(ADDR_W)) u_ilatch (
    .clk(clk), .rst_n(rst_n), .miss_i(imiss_detected), .addr_i(imiss_address),
    .busy_i(ifsm_busy), .clear_i(grant_i), .pending_o(ipend), .addr_o(iaddr)
  );

  cache_miss_latch #(.ADDR_W(ADDR_W)) u_dlatch (
    .clk(clk), .rst_n(rst_n), .miss_i(dmiss_detected), .addr_i(dmiss_address),
    .busy_i(dfsm_busy), .clear_i(grant_d), .pending_o(dpend), .addr_o(daddr)
  );

  // Word indices wrap modulo BLOCK_WORDS purely through IW-bit truncation.
  assign issue_idx = start_q + issue_cnt_q[IW-1:0];
  assign recv_idx  = start_q + recv_cnt_q[IW-1:0];

  assign ifsm_busy  = ipend | (state_q == FILL && owner_q == OWNER_I);
  assign dfsm_busy  = dpend | (state_q == FILL && owner_q == OWNER_D);
  assign fill_owner = owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_I;
      base_q      <= '0;
      start_q     <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      start_q     <= start_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    base_d           = base_q;
    start_d          = start_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    grant_i          = 1'b0;
    grant_d          = 1'b0;
    grant_addr       = '0;
    memory_req       = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_word_sel    = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (dpend) begin
          grant_d    = 1'b1;
          owner_d    = OWNER_D;
          grant_addr = daddr;
        end else if (ipend) begin
          grant_i    = 1'b1;
          owner_d    = OWNER_I;
          grant_addr = iaddr;
        end
        if (grant_i || grant_d) begin
          base_d      = grant_addr & ~BLK_MASK;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
          start_d     = grant_addr[OW+IW-1:OW];
`else
          start_d     = '0;
`endif
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end

      FILL: begin
        memory_req     = (issue_cnt_q < BW_C);
        memory_address = base_q + (ADDR_W'(issue_idx) << OW);
        if (memory_req) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
        end
        // Returns beyond what was issued are stray and must not write.
        write_data_array = memory_data_valid && (recv_cnt_q < issue_cnt_q);
        data_word_sel    = recv_idx;
        if (write_data_array) begin
          recv_cnt_d = recv_cnt_q + CW'(1);
          if (recv_cnt_q == LAST_C) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
